// File: rtl/nibble_serial_adder.sv
// Serial adder: adds two 4*NIBBLES-bit operands one nibble per clock through a single 4-bit ripple-carry adder.
// Optional signed-overflow output is enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.

module ripple_carry_adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign S[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[4];

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 Cin,
  output logic [4*NIBBLES-1:0] S,
  output logic                 Cout,
  output logic                 busy,
  output logic                 done
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  , output logic               ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          cin_reg;
  logic          carry;
  logic [IW-1:0] idx;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic       nib_cin;
  logic [3:0] nib_sum;
  logic       nib_cout;

  assign nib_a   = a_reg[idx*4 +: 4];
  assign nib_b   = b_reg[idx*4 +: 4];
  assign nib_cin = (idx == '0) ? cin_reg : carry;

  ripple_carry_adder4 u_rca (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (nib_cin),
    .S    (nib_sum),
    .Cout (nib_cout)
  );

  // busy/done are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      cin_reg <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      S       <= '0;
      Cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        ADD: begin
          S[idx*4 +: 4] <= nib_sum;
          carry         <= nib_cout;
          idx           <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            Cout  <= nib_cout;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            ovf   <= nib_cout ^ (nib_a[3] ^ nib_b[3] ^ nib_sum[3]);
`endif
          end
        end
        default: begin
          if (start) begin
            a_reg   <= A;
            b_reg   <= B;
            cin_reg <= Cin;
            idx     <= '0;
            state   <= ADD;
            busy    <= 1'b1;
            done    <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with NIBBLES=4.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to also check the ovf output.

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [15:0] S;
  logic        Cout;
  logic        busy;
  logic        done;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .S     (S),
    .Cout  (Cout),
    .busy  (busy),
    .done  (done)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , .ovf (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents operands with start for exactly one edge; returns 1ns after that edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    A     = a;
    B     = b;
    Cin   = cin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic runAdd(input string tag, input logic [15:0] exp_s, input logic exp_cout, input logic exp_ovf);
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_done_early"}, 32'(done), 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
    checkOutput({tag, "_S"}, 32'(S), 32'(exp_s));
    checkOutput({tag, "_Cout"}, 32'(Cout), 32'(exp_cout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_S", 32'(S), 32'h0);
    checkOutput("rst_Cout", 32'(Cout), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero operands, latency check
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    runAdd("zero", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("zero_done_pulse", 32'(done), 32'd0);
    checkOutput("zero_hold_S", 32'(S), 32'h0);

    // Carry ripples through every nibble
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    runAdd("chain", 16'h0000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("chain_hold_S", 32'(S), 32'h0000);
    checkOutput("chain_hold_Cout", 32'(Cout), 32'd1);

    // Carry-in, then back-to-back with start held into DONE
    applyStimulus(16'h1234, 16'h4321, 1'b1);
    runAdd("cin", 16'h5556, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    runAdd("b2b", 16'hFFFF, 1'b1, 1'b0);

    // Signed overflow
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    runAdd("ovf", 16'h8000, 1'b0, 1'b1);

    // Start during ADD must be ignored, operand changes too
    applyStimulus(16'h0F0F, 16'h0101, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    A     = 16'hFFFF;
    B     = 16'hFFFF;
    Cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ign_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("ign_done", 32'(done), 32'd1);
    checkOutput("ign_S", 32'(S), 32'h1010);
    checkOutput("ign_Cout", 32'(Cout), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("ign_single_done", 32'(done), 32'd0);
      checkOutput("ign_idle_busy", 32'(busy), 32'd0);
    end

    // Reset in the 3rd ADD cycle aborts the operation
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_S", 32'(S), 32'h0);
    checkOutput("abort_Cout", 32'(Cout), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    runAdd("after_rst", 16'h3333, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
